// File: rtl/neo_pkg.sv
// Shared types and constants for the NeoGeo ROM-to-SDRAM read bridge.
// Holds the FSM state encoding, the region codes and the P2 bank base address.
package neo_pkg;

  typedef enum logic [1:0] {
    sIdle = 2'd0,
    sReq  = 2'd1,
    sHold = 2'd2
  } neoState;

  typedef enum logic [1:0] {
    rRom  = 2'd0,
    rPort = 2'd1,
    rSrom = 2'd2
  } neoRegion;

  // P2 bank 0 begins one megabyte above the P1 ROM image.
  localparam logic [24:0] P2_BASE = 25'h100000;

endpackage

// File: rtl/neo_rom_cache.sv
// Single-entry read cache keyed by region and SDRAM byte address.
// Clearing the entry takes priority over a fill that arrives in the same cycle.
module neo_rom_cache
  import neo_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              invalidate,
  input  logic              fill,
  input  neoRegion          fillRegion,
  input  logic [24:0]       fillAddr,
  input  logic [DATA_W-1:0] fillData,
  input  neoRegion          lookRegion,
  input  logic [24:0]       lookAddr,
  output logic              hit,
  output logic [DATA_W-1:0] hitData
);

  logic              entryValid;
  neoRegion          entryRegion;
  logic [24:0]       entryAddr;
  logic [DATA_W-1:0] entryData;

  always_ff @(posedge clk) begin
    if (rst || invalidate) begin
      entryValid <= 1'b0;
    end else if (fill) begin
      entryValid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      entryRegion <= fillRegion;
      entryAddr   <= fillAddr;
      entryData   <= fillData;
    end
  end

  assign hit     = entryValid && (entryRegion == lookRegion) && (entryAddr == lookAddr);
  assign hitData = entryData;

endmodule

// File: rtl/neo_rom_bridge.sv
// Bridges 68K ROM/port/system-ROM read strobes to a request/ack SDRAM port,
// with P2 bank switching, a one-entry read cache and an ACK timeout.
module neo_rom_bridge
  import neo_pkg::*;
#(
  parameter int          TIMEOUT   = 255,
  parameter logic [24:0] SROM_BASE = 25'h1800000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:1] M68K_ADDR,
  input  logic [7:0]  M68K_DATA_IN,
  input  logic        nAS,
  input  logic        nROMOEL,
  input  logic        nROMOEU,
  input  logic        nPORTOEL,
  input  logic        nPORTOEU,
  input  logic        nSROMOEL,
  input  logic        nSROMOEU,
  input  logic        nPORTWEL,
  output logic        MEM_REQ,
  output logic [24:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [15:0] MEM_DATA,
  output logic [15:0] M68K_DOUT,
  output logic        DOUT_EN,
  output logic        nROMWAIT,
  output logic        nPWAIT0,
  output logic        nPWAIT1,
  output logic        PDTACK,
  output logic        ERR,
  input  logic        INVALIDATE
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  neoState     state, stateNext;
  neoRegion    region, regionNext, reqRegion;
  logic        memReqNext, doutEnNext, errNext, abortedNext;
  logic        aborted, abortNow;
  logic [24:0] memAddrNext, reqAddr;
  logic [15:0] doutNext;
  logic [7:0]  count, countNext;
  logic [2:0]  bank;
  logic        oeAllHighPrev, nPortWelPrev;
  logic        romLow, portLow, sromLow, start, bankLoad, ack;
  logic        cacheHit, cacheFill;
  logic [15:0] cacheData;
  logic        unusedBits;

  assign romLow  = ~nROMOEL  | ~nROMOEU;
  assign portLow = ~nPORTOEL | ~nPORTOEU;
  assign sromLow = ~nSROMOEL | ~nSROMOEU;
  assign start   = oeAllHighPrev & (romLow | portLow | sromLow);
  assign ack     = MEM_ACK & MEM_REQ;

  // Bank register sits at the top 16 bytes of the P2 window.
  assign bankLoad = nPortWelPrev & ~nPORTWEL & (&M68K_ADDR[19:4]);

  always_comb begin
    reqRegion = rSrom;
    if (romLow)       reqRegion = rRom;
    else if (portLow) reqRegion = rPort;
  end

  always_comb begin
    case (reqRegion)
      rRom:    reqAddr = {5'd0, M68K_ADDR[19:1], 1'b0};
      rPort:   reqAddr = P2_BASE + {2'b00, bank, 20'd0} + {5'd0, M68K_ADDR[19:1], 1'b0};
      default: reqAddr = SROM_BASE + {8'd0, M68K_ADDR[16:1], 1'b0};
    endcase
  end

  neo_rom_cache #(.DATA_W(16)) cache (
    .clk        (CLK),
    .rst        (RESET),
    .invalidate (INVALIDATE | bankLoad),
    .fill       (cacheFill),
    .fillRegion (region),
    .fillAddr   (MEM_ADDR),
    .fillData   (MEM_DATA),
    .lookRegion (reqRegion),
    .lookAddr   (reqAddr),
    .hit        (cacheHit),
    .hitData    (cacheData)
  );

  always_comb begin
    stateNext   = state;
    regionNext  = region;
    memReqNext  = MEM_REQ;
    memAddrNext = MEM_ADDR;
    doutNext    = M68K_DOUT;
    doutEnNext  = DOUT_EN;
    errNext     = ERR;
    countNext   = count;
    abortedNext = aborted;
    cacheFill   = 1'b0;
    abortNow    = aborted | nAS;
    case (state)
      sIdle: begin
        if (start) begin
          regionNext = reqRegion;
          if (cacheHit) begin
            stateNext  = sHold;
            doutNext   = cacheData;
            doutEnNext = 1'b1;
          end else begin
            stateNext   = sReq;
            memReqNext  = 1'b1;
            memAddrNext = reqAddr;
            countNext   = 8'd0;
            abortedNext = 1'b0;
          end
        end
      end
      sReq: begin
        // An ACK in the timeout cycle still delivers real data.
        if (ack || count == TIMEOUT_CNT) begin
          memReqNext = 1'b0;
          if (ack) begin
            doutNext  = MEM_DATA;
            cacheFill = 1'b1;
          end else begin
            doutNext = 16'hFFFF;
            errNext  = 1'b1;
          end
          if (abortNow) begin
            stateNext = sIdle;
          end else begin
            stateNext  = sHold;
            doutEnNext = 1'b1;
          end
        end else begin
          countNext   = count + 8'd1;
          abortedNext = abortNow;
        end
      end
      sHold: begin
        if (nAS) begin
          stateNext  = sIdle;
          doutEnNext = 1'b0;
        end
      end
      default: stateNext = sIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= sIdle;
      region        <= rRom;
      MEM_REQ       <= 1'b0;
      MEM_ADDR      <= 25'd0;
      M68K_DOUT     <= 16'd0;
      DOUT_EN       <= 1'b0;
      ERR           <= 1'b0;
      count         <= 8'd0;
      aborted       <= 1'b0;
      bank          <= 3'd0;
      oeAllHighPrev <= 1'b0;
      nPortWelPrev  <= 1'b0;
    end else begin
      state         <= stateNext;
      region        <= regionNext;
      MEM_REQ       <= memReqNext;
      MEM_ADDR      <= memAddrNext;
      M68K_DOUT     <= doutNext;
      DOUT_EN       <= doutEnNext;
      ERR           <= errNext;
      count         <= countNext;
      aborted       <= abortedNext;
      oeAllHighPrev <= ~(romLow | portLow | sromLow);
      nPortWelPrev  <= nPORTWEL;
      if (bankLoad) bank <= M68K_DATA_IN[2:0];
    end
  end

  assign nROMWAIT = ~((state == sReq) && (region != rPort));
  assign PDTACK   = (state == sHold) && (region == rPort);
  assign nPWAIT0  = 1'b1;
  assign nPWAIT1  = 1'b1;

  assign unusedBits = &{1'b0, M68K_ADDR[23:20], M68K_DATA_IN[7:3]};

endmodule

// File: doc/neo_rom_bridge.md
NEO_ROM_BRIDGE -- requirements
Module: neo_rom_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, ACK wait limit in CLK cycles (8-bit counter).
REQ-002 SHALL have parameter SROM_BASE, default 25'h1800000, SDRAM byte base of system ROM.
REQ-003 SHALL have ports: CLK in 1 system clock; RESET in 1 synchronous active-high reset.
REQ-004 SHALL have ports: M68K_ADDR in 23 (bits 23:1) 68K word address; M68K_DATA_IN in 8 low data byte for writes; nAS in 1 address strobe.
REQ-005 SHALL have ports: nROMOEL, nROMOEU, nPORTOEL, nPORTOEU, nSROMOEL, nSROMOEU in 1 each, decoded read strobes; nPORTWEL in 1 port write strobe.
REQ-006 SHALL have ports: MEM_REQ out 1; MEM_ADDR out 25 byte address, bit 0 always 0; MEM_ACK in 1; MEM_DATA in 16.
REQ-007 SHALL have ports: M68K_DOUT out 16 read data; DOUT_EN out 1 data valid/drive enable.
REQ-008 SHALL have ports: nROMWAIT out 1; nPWAIT0, nPWAIT1 out 1 (constant 1); PDTACK out 1; ERR out 1 sticky timeout flag; INVALIDATE in 1 cache flush.

Function
REQ-009 Start: a read cycle SHALL be detected on the first cycle any OE strobe is low after all OE strobes were high the previous cycle.
REQ-010 Region SHALL be ROM (nROMOEx), PORT (nPORTOEx) or SROM (nSROMOEx); priority ROM > PORT > SROM if several are low.
REQ-011 MEM_ADDR SHALL be: ROM {M68K_ADDR[19:1],0}; PORT 25'h100000 + BANK*25'h100000 + {M68K_ADDR[19:1],0}; SROM SROM_BASE + {M68K_ADDR[16:1],0}.
REQ-012 BANK SHALL be a 3-bit register loaded with M68K_DATA_IN[2:0] on the falling edge of nPORTWEL when M68K_ADDR[19:4] = all ones; PORT addresses use BANK captured at request time.
REQ-013 Cache: one entry (region, MEM_ADDR, data, valid); a bank load or INVALIDATE high SHALL clear valid in the following cycle.
REQ-014 FSM states IDLE, REQ, HOLD; IDLE->HOLD on start with cache hit (DOUT_EN high next cycle, no MEM_REQ).
REQ-015 IDLE->REQ on start with miss; MEM_REQ SHALL rise the cycle after start and remain high until MEM_ACK sampled high.
REQ-016 REQ->HOLD on MEM_ACK: MEM_REQ low, M68K_DOUT <= MEM_DATA, cache updated, DOUT_EN high next cycle.
REQ-017 REQ with counter = TIMEOUT and no ACK: ->HOLD, M68K_DOUT <= 16'hFFFF, ERR set, MEM_REQ dropped, cache unchanged.
REQ-018 HOLD->IDLE when nAS sampled high; DOUT_EN, PDTACK low and nROMWAIT high on the next cycle.
REQ-019 nAS high while in REQ (aborted cycle): SHALL stay in REQ until ACK/timeout, then go directly to IDLE without asserting DOUT_EN.
REQ-020 nROMWAIT SHALL be 0 while state=REQ with region ROM or SROM, else 1; PDTACK SHALL be 1 in HOLD with region PORT, else 0.
REQ-021 MEM_ACK while MEM_REQ low SHALL be ignored; ACK and timeout in same cycle: ACK wins.

Reset
REQ-022 RESET SHALL force IDLE, MEM_REQ 0, MEM_ADDR 0, M68K_DOUT 0, DOUT_EN 0, PDTACK 0, nROMWAIT 1, ERR 0, BANK 0, cache invalid, counter 0.
REQ-023 RESET mid-request SHALL drop MEM_REQ next edge; a late MEM_ACK after reset SHALL be ignored.

Structure
REQ-024 State encoding, region codes and the 25'h100000 P2 base SHALL live in shared package neo_pkg.
REQ-025 Cache SHALL be a sub-module neo_rom_cache (lookup, fill, invalidate); FSM, bank and timeout stay in top.

Verification
REQ-026 ROM read 0x001234, ACK after 5 cycles with 16'hBEEF -> MEM_ADDR 25'h001234, nROMWAIT low 6 cycles, M68K_DOUT 16'hBEEF with DOUT_EN.
REQ-027 Bank write 3 to 0x2FFFF1, then PORT read 0x200010 -> MEM_ADDR 25'h400010, PDTACK high after ACK.
REQ-028 Repeat of REQ-026 read -> no MEM_REQ, DOUT_EN high 1 cycle after start; after INVALIDATE pulse -> MEM_REQ issued again.
REQ-029 SROM read 0xC00002, no ACK -> MEM_REQ dropped after 255 cycles, M68K_DOUT 16'hFFFF, ERR 1 until RESET.
REQ-030 RESET asserted 2 cycles into a ROM request, ACK 3 cycles later -> MEM_REQ 0, DOUT_EN stays 0, state IDLE.
